fgpio_ext: RTL

FGPIO_EXT -- requirements
Module: fgpio_ext

---
 rtl/fgpio_ext_if.sv | 31 +++
 rtl/fgpio_ext.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fgpio_ext_if.sv
// -----------------------------------------------------------------------------
// fgpio_ext_if : request/response bus between a core and the fgpio_ext block.
//   fgpio_req      request, held stable until ack (or dropped to abort)
//   fgpio_funct7   opcode
//   fgpio_rs1_val  operand 1
//   fgpio_rs2_val  operand 2 (pin mask for most opcodes)
//   fgpio_ack      completion strobe
//   fgpio_error    error flag, meaningful only with ack
//   fgpio_rd_val   result, meaningful only with ack
//   fgpio_busy     high while a multi-cycle operation is in flight
// -----------------------------------------------------------------------------
interface fgpio_ext_if;
    logic        fgpio_req;
    logic [6:0]  fgpio_funct7;
    logic [31:0] fgpio_rs1_val;
    logic [31:0] fgpio_rs2_val;
    logic        fgpio_ack;
    logic        fgpio_error;
    logic [31:0] fgpio_rd_val;
    logic        fgpio_busy;

    modport master (
        output fgpio_req, fgpio_funct7, fgpio_rs1_val, fgpio_rs2_val,
        input  fgpio_ack, fgpio_error, fgpio_rd_val, fgpio_busy
    );

    modport slave (
        input  fgpio_req, fgpio_funct7, fgpio_rs1_val, fgpio_rs2_val,
        output fgpio_ack, fgpio_error, fgpio_rd_val, fgpio_busy
    );
endinterface

// File: rtl/fgpio_ext.sv
// -----------------------------------------------------------------------------
// fgpio_ext : fast GPIO extension. Raw/bit/edge reads, masked writes, bounded
// wait-for-pattern and fixed-length output pulses, driven by an opcode bus.
//   clk_neg_i     single clock, all flops on its rising edge
//   rst_ni        synchronous active-low reset
//   bus           fgpio_ext_if slave port (req/funct7/rs1/rs2 -> ack/error/rd/busy)
//   gpio_dir      pin direction, 1 = output
//   gpio_in_val   asynchronous pin inputs
//   gpio_out_val  pin output values
// -----------------------------------------------------------------------------
module fgpio_ext #(
    parameter int GPIO_NUM    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clk_neg_i,
    input  logic                rst_ni,
    fgpio_ext_if.slave          bus,
    output logic [GPIO_NUM-1:0] gpio_dir,
    input  logic [GPIO_NUM-1:0] gpio_in_val,
    output logic [GPIO_NUM-1:0] gpio_out_val
);
    localparam logic [6:0] OP_IN_RAW    = 7'b0000000;
    localparam logic [6:0] OP_IN_BIT    = 7'b0000001;
    localparam logic [6:0] OP_IN_EDGE   = 7'b0000010;
    localparam logic [6:0] OP_IN_WAIT   = 7'b0000011;
    localparam logic [6:0] OP_CFG_TMO   = 7'b0100000;
    localparam logic [6:0] OP_CFG_EDGE  = 7'b0100001;
    localparam logic [6:0] OP_OUT_RAW   = 7'b1000000;
    localparam logic [6:0] OP_OUT_AND   = 7'b1000001;
    localparam logic [6:0] OP_OUT_TGL   = 7'b1000010;
    localparam logic [6:0] OP_OUT_PULSE = 7'b1000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [GPIO_NUM-1:0] dir_q, dir_d, out_q, out_d;
    logic [GPIO_NUM-1:0] flags_q, sin_d_q, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [CNT_W-1:0]    timeout_q, timeout_d, elapsed_q, elapsed_d, cnt_q, cnt_d;

    logic [GPIO_NUM-1:0] sin_s, mask_s, rs1_g_s, set_s, clr_s;
    logic [CNT_W-1:0]    n_s;
    logic [4:0]          idx_s;
    logic [31:0]         sin_ext_s, onehot_s, rd_s;
    logic                match_s, tmo_hit_s, ack_s, err_s, unused_ok_s;

    // Optional input synchroniser; depth 0 uses the pins directly.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sin_s = gpio_in_val;
        end else begin : g_sync
            logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
            // Shift chain clearing to zero on reset.
            always_ff @(posedge clk_neg_i) begin
                if (!rst_ni) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= gpio_in_val;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign sin_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign mask_s    = bus.fgpio_rs2_val[GPIO_NUM-1:0];
    assign rs1_g_s   = bus.fgpio_rs1_val[GPIO_NUM-1:0];
    assign n_s       = bus.fgpio_rs1_val[CNT_W-1:0];
    assign idx_s     = bus.fgpio_rs1_val[4:0];
    assign sin_ext_s = 32'(sin_s);
    assign onehot_s  = 32'd1 << idx_s;
    assign match_s   = ((sin_s & mask_s) == (rs1_g_s & mask_s));
    assign tmo_hit_s = (timeout_q != '0) && (elapsed_q == timeout_q);
    assign set_s     = (sin_s & ~sin_d_q & rise_en_q) | (~sin_s & sin_d_q & fall_en_q);
    // Operand bits above the pin/counter widths are intentionally ignored.
    assign unused_ok_s = ^{bus.fgpio_rs1_val, bus.fgpio_rs2_val};

    // State and datapath registers; reset overrides every pending update.
    always_ff @(posedge clk_neg_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dir_q     <= '0;
            out_q     <= '0;
            flags_q   <= '0;
            sin_d_q   <= '0;
            timeout_q <= '0;
            rise_en_q <= '1;
            fall_en_q <= '0;
            elapsed_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            flags_q   <= (flags_q & ~clr_s) | set_s;  // new edge beats a clear
            sin_d_q   <= sin_s;
            timeout_q <= timeout_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            elapsed_q <= elapsed_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic of the IDLE/WAIT/PULSE controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fgpio_req && (bus.fgpio_funct7 == OP_IN_WAIT) && !match_s) begin
                    state_d = ST_WAIT;
                end else if (bus.fgpio_req && (bus.fgpio_funct7 == OP_OUT_PULSE) && (n_s != '0)) begin
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.fgpio_req || match_s || tmo_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PULSE: begin
                if (!bus.fgpio_req || (cnt_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response and register-update logic; ack is suppressed while in reset.
    always_comb begin
        ack_s     = 1'b0;
        err_s     = 1'b0;
        rd_s      = 32'd0;
        clr_s     = '0;
        dir_d     = dir_q;
        out_d     = out_q;
        timeout_d = timeout_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        elapsed_d = elapsed_q;
        cnt_d     = cnt_q;
        if (!rst_ni || !bus.fgpio_req) begin
            ack_s = 1'b0;
            // An abort mid-pulse puts the pins back to their pre-pulse value.
            if (state_q == ST_PULSE) begin
                out_d = out_q ^ mask_s;
            end else begin
                out_d = out_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_s = 1'b1;
                    case (bus.fgpio_funct7)
                        OP_IN_RAW: begin
                            rd_s  = 32'(sin_s & mask_s);
                            dir_d = dir_q & ~mask_s;
                        end
                        OP_IN_BIT: begin
                            if ({27'd0, idx_s} >= 32'(GPIO_NUM)) begin
                                err_s = 1'b1;
                            end else begin
                                rd_s  = 32'(sin_ext_s[idx_s]) << bus.fgpio_rs2_val[4:0];
                                dir_d = dir_q & ~onehot_s[GPIO_NUM-1:0];
                            end
                        end
                        OP_IN_EDGE: begin
                            rd_s  = 32'(flags_q & mask_s);
                            clr_s = mask_s;
                        end
                        OP_IN_WAIT: begin
                            if (match_s) begin
                                rd_s = 32'd0;
                            end else begin
                                ack_s     = 1'b0;
                                elapsed_d = CNT_W'(1);
                            end
                        end
                        OP_CFG_TMO: begin
                            rd_s      = 32'(timeout_q);
                            timeout_d = n_s;
                        end
                        OP_CFG_EDGE: begin
                            rise_en_d = rs1_g_s;
                            fall_en_d = mask_s;
                        end
                        OP_OUT_RAW: begin
                            dir_d = dir_q | mask_s;
                            out_d = (out_q & ~mask_s) | (rs1_g_s & mask_s);
                        end
                        OP_OUT_AND: begin
                            dir_d = '1;
                            out_d = rs1_g_s & mask_s;
                        end
                        OP_OUT_TGL: begin
                            dir_d = dir_q | mask_s;
                            out_d = out_q ^ mask_s;
                        end
                        OP_OUT_PULSE: begin
                            if (n_s != '0) begin
                                ack_s = 1'b0;
                                dir_d = dir_q | mask_s;
                                out_d = out_q ^ mask_s;
                                cnt_d = n_s;
                            end else begin
                                ack_s = 1'b1;
                            end
                        end
                        default: err_s = 1'b1;
                    endcase
                end
                ST_WAIT: begin
                    if (match_s) begin
                        ack_s = 1'b1;
                        rd_s  = 32'(elapsed_q);
                    end else if (tmo_hit_s) begin
                        ack_s = 1'b1;
                        rd_s  = 32'h8000_0000 | 32'(elapsed_q);
                    end else begin
                        elapsed_d = elapsed_q + CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        ack_s = 1'b1;
                        out_d = out_q ^ mask_s;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ack_s = 1'b0;
            endcase
        end
    end

    assign bus.fgpio_ack    = ack_s;
    assign bus.fgpio_error  = ack_s & err_s;
    assign bus.fgpio_rd_val = ack_s ? rd_s : 32'd0;
    assign bus.fgpio_busy   = (state_q != ST_IDLE);
    assign gpio_dir         = dir_q;
    assign gpio_out_val     = out_q;
endmodule
